pps_sram_arbiter: RTL and testbench

- Shares the single external SRAM port between instruction fetch (IF) and data load/store (EX).
- Sits between the processor memory interface (inst_addr/inst, data_addr/data_out/data_in/bwe) and the SRAM pins.
- Sequences each access as a multi-cycle SRAM transfer.
- Produces a stall signal that the pipeline uses to hold PC and pipeline registers until its requests complete.

---
 rtl/pps_sram_arbiter.sv | 102 ++++++++++
 tb/tb_pps_sram_arbiter.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pps_sram_arbiter.sv
// pps_sram_arbiter: shares one external SRAM port between instruction fetch and data access.
// Data has fixed priority; each grant runs a WAIT_CYC-cycle transfer and ends with a one-cycle ack.
module pps_sram_arbiter #(
  parameter int ADDR_W   = 18,
  parameter int WAIT_CYC = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [31:0]       if_addr,
  output logic [31:0]       if_rdata,
  output logic              if_ack,
  input  logic              d_req,
  input  logic [3:0]        d_we,
  input  logic [31:0]       d_addr,
  input  logic [31:0]       d_wdata,
  output logic [31:0]       d_rdata,
  output logic              d_ack,
  output logic              stall,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [31:0]       sram_dq_out,
  output logic              sram_dq_oe,
  input  logic [31:0]       sram_dq_in,
  output logic              sram_ce_n,
  output logic              sram_oe_n,
  output logic              sram_we_n,
  output logic [3:0]        sram_be_n
);
  typedef enum logic {IDLE, ACCESS} state_t;
  typedef enum logic {INST, DATA} owner_t;
  state_t state, state_nxt;
  owner_t owner;
  logic [3:0] cnt;
  logic wr, grant_d, grant_i, g_wr, done;
  logic unused;
  assign unused = ^{if_addr[31:ADDR_W+2], if_addr[1:0], d_addr[31:ADDR_W+2], d_addr[1:0]};
  assign stall = (d_req & ~d_ack) | (if_req & ~if_ack);
  always_comb begin
    grant_d = 1'b0;
    grant_i = 1'b0;
    done = 1'b0;
    state_nxt = state;
    if (state == IDLE) begin
      grant_d = d_req & ~d_ack;
      grant_i = ~grant_d & if_req & ~if_ack;
      state_nxt = (grant_d | grant_i) ? ACCESS : IDLE;
    end else begin
      done = cnt == 4'd0;
      state_nxt = done ? IDLE : ACCESS;
    end
    g_wr = grant_d & |d_we;
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= IDLE;
    else state <= state_nxt;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      owner <= INST;
      wr <= 1'b0;
      cnt <= 4'd0;
      sram_addr <= '0;
      sram_dq_out <= '0;
      sram_dq_oe <= 1'b0;
      sram_ce_n <= 1'b1;
      sram_oe_n <= 1'b1;
      sram_we_n <= 1'b1;
      sram_be_n <= 4'hf;
      if_ack <= 1'b0;
      d_ack <= 1'b0;
      if_rdata <= '0;
      d_rdata <= '0;
    end else begin
      if_ack <= 1'b0;
      d_ack <= 1'b0;
      if (grant_d | grant_i) begin
        owner <= grant_d ? DATA : INST;
        wr <= g_wr;
        cnt <= 4'(WAIT_CYC - 1);
        sram_addr <= grant_d ? d_addr[ADDR_W+1:2] : if_addr[ADDR_W+1:2];
        sram_ce_n <= 1'b0;
        sram_oe_n <= g_wr;
        sram_we_n <= ~g_wr;
        sram_be_n <= g_wr ? ~d_we : 4'h0;
        sram_dq_oe <= g_wr;
        if (g_wr) sram_dq_out <= d_wdata;
      end else if (done) begin
        if (!wr && owner == DATA) d_rdata <= sram_dq_in;
        if (!wr && owner == INST) if_rdata <= sram_dq_in;
        d_ack <= owner == DATA;
        if_ack <= owner == INST;
        sram_ce_n <= 1'b1;
        sram_oe_n <= 1'b1;
        sram_we_n <= 1'b1;
        sram_be_n <= 4'hf;
        sram_dq_oe <= 1'b0;
      end else if (state == ACCESS) begin
        cnt <= cnt - 4'd1;
        // address and data stay driven through the last cycle for SRAM hold time
        if (cnt == 4'd1) sram_we_n <= 1'b1;
      end
    end
endmodule

// File: tb/tb_pps_sram_arbiter.sv
// tb_pps_sram_arbiter: directed and randomized checks of pps_sram_arbiter against a cycle-timeline
// and memory model; instance 0 runs WAIT_CYC=2, instance 1 runs WAIT_CYC=4.
module tb_pps_sram_arbiter;
  localparam int W = 2;
  logic clk = 1'b0, rst = 1'b0;
  logic if_req = 1'b0, d_req = 1'b0;
  logic [31:0] if_addr = '0, d_addr = '0, d_wdata = '0;
  logic [3:0] d_we = '0;
  logic [31:0] if_rdata [2], d_rdata [2], dq_out [2], dq_in [2];
  logic if_ack [2], d_ack [2], stall [2], dq_oe [2], ce_n [2], oe_n [2], we_n [2];
  logic [17:0] sram_addr [2];
  logic [3:0] be_n [2];
  logic [31:0] mem [256];
  logic [31:0] model_mem [256];
  logic [31:0] exp_drd = '0, exp_ird = '0;
  int errors = 0, checks = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    pps_sram_arbiter #(.ADDR_W(18), .WAIT_CYC(2 + 2 * g)) dut (
      .clk(clk), .rst(rst), .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata[g]), .if_ack(if_ack[g]),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_rdata(d_rdata[g]), .d_ack(d_ack[g]),
      .stall(stall[g]), .sram_addr(sram_addr[g]), .sram_dq_out(dq_out[g]), .sram_dq_oe(dq_oe[g]),
      .sram_dq_in(dq_in[g]), .sram_ce_n(ce_n[g]), .sram_oe_n(oe_n[g]), .sram_we_n(we_n[g]), .sram_be_n(be_n[g]));
    assign dq_in[g] = mem[sram_addr[g][7:0]];
  end

  // SRAM array, written only by instance 0
  always @(posedge clk)
    if (rst && !ce_n[0] && !we_n[0])
      for (int b = 0; b < 4; b++)
        if (!be_n[0][b]) mem[sram_addr[0][7:0]][8*b +: 8] = dq_out[0][8*b +: 8];

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  // One scenario on instance 0: access k occupies cycles k*(W+1)+1..k*(W+1)+W, its ack comes at (k+1)*(W+1).
  task automatic run_pair(input bit do_d, input bit do_i, input logic [3:0] we,
                          input logic [31:0] da, input logic [31:0] ia, input logic [31:0] wd);
    int n, dack, iack, k, pos;
    bit act, wr;
    logic [7:0] dw, iw, bus_exp;
    logic [31:0] a;
    dw = da[9:2];
    iw = ia[9:2];
    n = int'(do_d) + int'(do_i);
    dack = do_d ? W + 1 : -1;
    iack = do_i ? n * (W + 1) : -1;
    if (do_d && we == 4'h0) exp_drd = model_mem[dw];
    for (int b = 0; b < 4; b++) if (do_d && we[b]) model_mem[dw][8*b +: 8] = wd[8*b +: 8];
    if (do_i) exp_ird = model_mem[iw];
    next();
    d_req = do_d; d_we = we; d_addr = da; d_wdata = wd; if_req = do_i; if_addr = ia;
    for (int c = 0; c <= n * (W + 1); c++) begin
      if (c > 0) next();
      if (c == 1 && do_d) begin
        d_addr = $urandom; d_wdata = $urandom; d_we = 4'($urandom);
      end else if (c == 1) if_addr = $urandom;
      if (c == dack + 1) d_req = 1'b0;
      @(negedge clk);
      k = (c - 1) / (W + 1);
      pos = (c - 1) % (W + 1);
      act = c >= 1 && pos < W && k < n;
      wr = act && do_d && k == 0 && we != 4'h0;
      a = (do_d && k == 0) ? da : ia;
      bus_exp = act ? {1'b0, wr, !(wr && pos < W - 1), wr ? ~we : 4'h0, wr} : 8'b1111_1110;
      checks++;
      if ({ce_n[0], oe_n[0], we_n[0], be_n[0], dq_oe[0]} !== bus_exp) begin
        errors++;
        $display("FAIL bus c=%0d ce,oe,we,be,oe: got %b exp %b", c, {ce_n[0], oe_n[0], we_n[0], be_n[0], dq_oe[0]}, bus_exp);
      end
      if (act) begin
        checks++;
        if (sram_addr[0] !== a[19:2]) begin
          errors++;
          $display("FAIL sram_addr c=%0d got %h exp %h", c, sram_addr[0], a[19:2]);
        end
        if (wr) begin
          checks++;
          if (dq_out[0] !== wd) begin
            errors++;
            $display("FAIL dq_out c=%0d got %h exp %h", c, dq_out[0], wd);
          end
        end
      end
      checks++;
      if ({stall[0], d_ack[0], if_ack[0]} !== {(do_d && c < dack) || (do_i && c < iack), c == dack, c == iack}) begin
        errors++;
        $display("FAIL stall/acks c=%0d got %b exp %b", c, {stall[0], d_ack[0], if_ack[0]},
                 {(do_d && c < dack) || (do_i && c < iack), c == dack, c == iack});
      end
      if (c == dack) begin
        checks++;
        if (d_rdata[0] !== exp_drd) begin
          errors++;
          $display("FAIL d_rdata got %h exp %h", d_rdata[0], exp_drd);
        end
      end
      if (c == iack) begin
        checks++;
        if (if_rdata[0] !== exp_ird) begin
          errors++;
          $display("FAIL if_rdata got %h exp %h", if_rdata[0], exp_ird);
        end
      end
    end
    next();
    d_req = 1'b0;
    if_req = 1'b0;
  endtask

  task automatic test_fetch();
    mem[8'h10] = 32'h2402_0005;
    model_mem[8'h10] = 32'h2402_0005;
    run_pair(1'b0, 1'b1, 4'h0, 32'h0, 32'h0000_0040, 32'h0);
    checks++;
    if (if_rdata[0] !== 32'h2402_0005) begin
      errors++;
      $display("FAIL fetch_word got %h exp 24020005", if_rdata[0]);
    end
  endtask

  task automatic test_byte_store();
    run_pair(1'b1, 1'b0, 4'b0100, 32'h104, 32'h0, 32'h00AB_0000);
    run_pair(1'b1, 1'b0, 4'b0000, 32'h104, 32'h0, 32'h0);
    checks++;
    if (d_rdata[0][23:16] !== 8'hAB) begin
      errors++;
      $display("FAIL store_byte got %h exp ab", d_rdata[0][23:16]);
    end
  endtask

  task automatic test_reset();
    next();
    d_req = 1'b1; d_we = 4'h0; d_addr = 32'h300; if_req = 1'b1; if_addr = 32'h44;
    next();
    #2 rst = 1'b0; d_req = 1'b0; if_req = 1'b0;
    #1;
    for (int g = 0; g < 2; g++) begin
      checks++;
      if ({ce_n[g], oe_n[g], we_n[g], be_n[g], dq_oe[g]} !== 8'b1111_1110) begin
        errors++;
        $display("FAIL reset_bus inst=%0d got %b exp 11111110", g, {ce_n[g], oe_n[g], we_n[g], be_n[g], dq_oe[g]});
      end
      checks++;
      if ({sram_addr[g], dq_out[g]} !== 50'b0) begin
        errors++;
        $display("FAIL reset_addr_data inst=%0d got %h/%h exp 0/0", g, sram_addr[g], dq_out[g]);
      end
      checks++;
      if ({if_ack[g], d_ack[g], if_rdata[g], d_rdata[g], stall[g]} !== 67'b0) begin
        errors++;
        $display("FAIL reset_cpu inst=%0d acks=%b%b if_rdata=%h d_rdata=%h stall=%b exp all 0",
                 g, if_ack[g], d_ack[g], if_rdata[g], d_rdata[g], stall[g]);
      end
    end
    exp_drd = '0;
    exp_ird = '0;
    next();
    rst = 1'b1;
  endtask

  task automatic test_collision();
    run_pair(1'b1, 1'b1, 4'h0, 32'h200, 32'h80, 32'h0);
  endtask

  task automatic test_random();
    for (int it = 0; it < 40; it++) begin
      bit dd, ii;
      dd = 1'($urandom);
      ii = 1'($urandom) | !dd;
      run_pair(dd, ii, $urandom_range(0, 1) ? 4'($urandom_range(1, 15)) : 4'h0,
               ($urandom & 32'hFFF0_0003) | (32'($urandom_range(0, 255)) << 2),
               ($urandom & 32'hFFF0_0003) | (32'($urandom_range(0, 255)) << 2), $urandom);
    end
  endtask

  task automatic test_wait4();
    logic [31:0] exp;
    logic [2:0] ctl;
    #2 rst = 1'b0;
    next();
    rst = 1'b1;
    exp_drd = '0;
    exp_ird = '0;
    exp = model_mem[2];
    d_req = 1'b1; d_we = 4'h0; d_addr = 32'h8;
    for (int c = 1; c <= 7; c++) begin
      next();
      @(negedge clk);
      ctl = c <= 4 ? 3'b000 : c == 5 ? 3'b111 : c == 6 ? 3'b110 : 3'b000;
      checks++;
      if ({ce_n[1], oe_n[1], d_ack[1]} !== ctl) begin
        errors++;
        $display("FAIL w4_ctl c=%0d ce,oe,ack got %b exp %b", c, {ce_n[1], oe_n[1], d_ack[1]}, ctl);
      end
      if (c <= 4 || c == 7) begin
        checks++;
        if (sram_addr[1] !== 18'h2) begin
          errors++;
          $display("FAIL w4_addr c=%0d got %h exp 2", c, sram_addr[1]);
        end
      end
      if (c == 5) begin
        checks++;
        if (d_rdata[1] !== exp) begin
          errors++;
          $display("FAIL w4_rdata got %h exp %h", d_rdata[1], exp);
        end
      end
    end
    d_req = 1'b0;
    repeat (6) next();
  endtask

  task automatic test_abort();
    next();
    d_req = 1'b1; d_we = 4'hF; d_addr = 32'h3C; d_wdata = 32'hDEAD_BEEF;
    next();
    @(negedge clk);
    checks++;
    if ({ce_n[0], we_n[0]} !== 2'b00) begin
      errors++;
      $display("FAIL abort_pre ce,we got %b exp 00", {ce_n[0], we_n[0]});
    end
    #1 rst = 1'b0; d_req = 1'b0;
    #1;
    checks++;
    if ({ce_n[0], we_n[0], ce_n[1], we_n[1]} !== 4'hF) begin
      errors++;
      $display("FAIL abort_bus ce,we got %b exp 1111", {ce_n[0], we_n[0], ce_n[1], we_n[1]});
    end
    next();
    next();
    rst = 1'b1;
    for (int c = 0; c < 10; c++) begin
      next();
      @(negedge clk);
      checks++;
      if ({d_ack[0], if_ack[0], d_ack[1], if_ack[1]} !== 4'h0) begin
        errors++;
        $display("FAIL abort_ack c=%0d got %b exp 0000", c, {d_ack[0], if_ack[0], d_ack[1], if_ack[1]});
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      mem[i] = (i * 32'h9E37_79B1) ^ 32'h5A5A_0000;
      model_mem[i] = (i * 32'h9E37_79B1) ^ 32'h5A5A_0000;
    end
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    test_fetch();
    test_byte_store();
    test_reset();
    test_collision();
    test_random();
    test_wait4();
    test_abort();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
